complex_operand_packer: RTL

//  Upstream stage of complex_matrix_mul. Accepts one complex element pair (a, b) per beat over valid/ready.

---
 rtl/cplx_pkg.sv | 15 +
 rtl/cpack_bank.sv | 83 ++++++++
 rtl/complex_operand_packer.sv | 113 +++++++++++
 3 files changed

// File: rtl/cplx_pkg.sv
// Purpose : shared types and constants for the complex operand packer.
// Contents: operand slot ordering within a pair, per-bank state, FP64 +0.0 pattern.
// Used by : cpack_bank, complex_operand_packer.
package cplx_pkg;

  localparam int NUM_OPERANDS = 4;

  // Order of the four scalars of one element pair inside the flat vector.
  typedef enum logic [1:0] {OP_A_RE, OP_A_IM, OP_B_RE, OP_B_IM} op_idx_e;

  typedef enum logic {FILL, HOLD} cpack_state_e;

  localparam logic [63:0] FP64_ZERO = 64'h0;

endpackage

// File: rtl/cpack_bank.sv
// Purpose : one operand buffer with its FILL/HOLD FSM, write index and zero-pad logic.
// Latency : completing beat at edge N -> hold_o=1 in cycle N+1.
// Backpr. : accepts writes only in FILL; stays in HOLD until rel_i (or flush_i / rst_i).
// Ports   : clk_i/rst_i (async, active-high), flush_i, wr_i/last_i/pair_i (accepted beat),
//           rel_i (release handshake), hold_o, count_o (beats written), data_o (flat vector).
module cpack_bank
  import cplx_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(SIZE + 1)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  input  logic                                      wr_i,
  input  logic                                      last_i,
  input  logic [NUM_OPERANDS-1:0][WIDTH-1:0]        pair_i,
  input  logic                                      rel_i,
  output logic                                      hold_o,
  output logic [CW-1:0]                             count_o,
  output logic [SIZE*NUM_OPERANDS-1:0][WIDTH-1:0]   data_o
);

  cpack_state_e                                r_state, w_state_nxt;
  logic [CW-1:0]                               r_idx, w_idx_nxt;
  logic [SIZE*NUM_OPERANDS-1:0][WIDTH-1:0]     r_data;
  logic                                        w_wr;
  logic                                        w_done;

  assign w_wr   = wr_i && !flush_i && (r_state == FILL);
  // Completion: either the final slot or an early last; remaining slots get +0.0.
  assign w_done = w_wr && (last_i || (r_idx == CW'(SIZE - 1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= FILL;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (flush_i) begin
      w_state_nxt = FILL;
      w_idx_nxt   = '0;
    end else if (r_state == FILL) begin
      if (w_wr) begin
        // idx keeps the accepted-beat count through HOLD; it clears on release.
        w_idx_nxt = r_idx + CW'(1);
        if (w_done) w_state_nxt = HOLD;
      end
    end else begin
      if (rel_i) begin
        w_state_nxt = FILL;
        w_idx_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data <= '0;
    end else if (w_wr) begin
      for (int p = 0; p < SIZE; p++) begin
        if (CW'(p) == r_idx) begin
          for (int k = 0; k < NUM_OPERANDS; k++) r_data[p*NUM_OPERANDS+k] <= pair_i[k];
        end else if (w_done && (CW'(p) > r_idx)) begin
          for (int k = 0; k < NUM_OPERANDS; k++) r_data[p*NUM_OPERANDS+k] <= WIDTH'(FP64_ZERO);
        end
      end
    end
  end

  assign hold_o  = (r_state == HOLD);
  assign count_o = r_idx;
  assign data_o  = r_data;

endmodule

// File: rtl/complex_operand_packer.sv
// Purpose : packs SIZE complex (a,b) pairs into the flat operand vector for complex_matrix_mul.
// Latency : last beat accepted at edge N -> out_valid_o=1 in cycle N+1; no comb path in_* -> out_*.
// Backpr. : vector held stable until out_ready_i; in_ready_o=0 while no bank is free to fill.
// Ports   : clk_i, rst_i (async, active-high), flush_i, in_valid_i/in_ready_o/in_last_i,
//           a_re_i/a_im_i/b_re_i/b_im_i, operands_o/out_valid_o/out_ready_i, count_o, busy_o.
// Config  : define CPACK_PINGPONG_EN for two banks (fill one while the other holds).
module complex_operand_packer
  import cplx_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    flush_i,
  input  logic                                    in_valid_i,
  output logic                                    in_ready_o,
  input  logic                                    in_last_i,
  input  logic [WIDTH-1:0]                        a_re_i,
  input  logic [WIDTH-1:0]                        a_im_i,
  input  logic [WIDTH-1:0]                        b_re_i,
  input  logic [WIDTH-1:0]                        b_im_i,
  output logic [SIZE*NUM_OPERANDS-1:0][WIDTH-1:0] operands_o,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic [$clog2(SIZE+1)-1:0]               count_o,
  output logic                                    busy_o
);

  localparam int CW = $clog2(SIZE + 1);

  logic [NUM_OPERANDS-1:0][WIDTH-1:0] w_pair;
  logic                               w_acc;
  logic                               w_rel;

  always_comb begin
    w_pair          = '0;
    w_pair[OP_A_RE] = a_re_i;
    w_pair[OP_A_IM] = a_im_i;
    w_pair[OP_B_RE] = b_re_i;
    w_pair[OP_B_IM] = b_im_i;
  end

`ifdef CPACK_PINGPONG_EN
  logic                                             r_wr_sel, r_rd_sel;
  logic [1:0]                                       w_hold;
  logic [1:0][CW-1:0]                               w_cnt;
  logic [1:0][SIZE*NUM_OPERANDS-1:0][WIDTH-1:0]     w_data;
  logic                                             w_done;

  // in_ready_o is forced low during reset even though the banks sit in FILL.
  assign in_ready_o  = !rst_i && !w_hold[r_wr_sel];
  assign out_valid_o = w_hold[r_rd_sel];
  assign w_acc       = in_valid_i && in_ready_o && !flush_i;
  assign w_rel       = out_valid_o && out_ready_i && !flush_i;
  assign w_done      = w_acc && (in_last_i || (w_cnt[r_wr_sel] == CW'(SIZE - 1)));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    cpack_bank #(.SIZE(SIZE), .WIDTH(WIDTH), .CW(CW)) u_bank (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .wr_i    (w_acc && (r_wr_sel == 1'(b))),
      .last_i  (in_last_i),
      .pair_i  (w_pair),
      .rel_i   (w_rel && (r_rd_sel == 1'(b))),
      .hold_o  (w_hold[b]),
      .count_o (w_cnt[b]),
      .data_o  (w_data[b])
    );
  end

  // Write and read pointers each toggle on their own event, so banks release in fill order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
    end else if (flush_i) begin
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      if (w_done) r_wr_sel <= ~r_wr_sel;
      if (w_rel)  r_rd_sel <= ~r_rd_sel;
    end
  end

  assign operands_o = w_data[r_rd_sel];
  assign count_o    = w_cnt[r_wr_sel];
`else
  logic w_hold;

  assign in_ready_o  = !rst_i && !w_hold;
  assign out_valid_o = w_hold;
  assign w_acc       = in_valid_i && in_ready_o && !flush_i;
  assign w_rel       = out_valid_o && out_ready_i && !flush_i;

  cpack_bank #(.SIZE(SIZE), .WIDTH(WIDTH), .CW(CW)) u_bank (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .wr_i    (w_acc),
    .last_i  (in_last_i),
    .pair_i  (w_pair),
    .rel_i   (w_rel),
    .hold_o  (w_hold),
    .count_o (count_o),
    .data_o  (operands_o)
  );
`endif

  assign busy_o = (count_o != '0) || out_valid_o;

endmodule
